// File: rtl/bw_input_pkg.sv
// rtl/bw_input_pkg.sv - shared types and constants for the Black Widow family input controller
package bw_input_pkg;

    typedef enum logic [1:0] {
        GAME_BWIDOW   = 2'd0,
        GAME_GRAVITAR = 2'd1,
        GAME_LUNARBAT = 2'd2,
        GAME_SPACDUEL = 2'd3
    } game_t;

    typedef enum logic {
        COIN_IDLE = 1'b0,
        COIN_HOLD = 1'b1
    } coin_state_t;

    localparam logic [7:0] SC_UP       = 8'h75;
    localparam logic [7:0] SC_DOWN     = 8'h72;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;
    localparam logic [7:0] SC_START1_A = 8'h05;
    localparam logic [7:0] SC_START1_B = 8'h16;
    localparam logic [7:0] SC_START2_A = 8'h06;
    localparam logic [7:0] SC_START2_B = 8'h1E;
    localparam logic [7:0] SC_FIRE_A   = 8'h14;
    localparam logic [7:0] SC_FIRE_B   = 8'h11;
    localparam logic [7:0] SC_FIRE_C   = 8'h29;
    localparam logic [7:0] SC_FIRE_D   = 8'h12;
    localparam logic [7:0] SC_COIN1    = 8'h2E;
    localparam logic [7:0] SC_COIN2    = 8'h36;

    localparam logic [7:0] IOCTL_IDX_GAME = 8'd1;
    localparam logic [7:0] IOCTL_IDX_DIP  = 8'd254;

    localparam int COIN_MIN_DEFAULT = 2500;

endpackage

// File: rtl/bw_coin_stretch.sv
// rtl/bw_coin_stretch.sv - stretches short coin pulses to a minimum asserted length
module bw_coin_stretch
    import bw_input_pkg::*;
#(
    parameter int COIN_MIN = COIN_MIN_DEFAULT
) (
    input  logic clk_25,
    input  logic RESET_L,
    input  logic coin_raw,
    output logic coin
);

    localparam int CW = (COIN_MIN > 2) ? $clog2(COIN_MIN) : 1;
    // The raw cycle that triggers the stretch counts toward the minimum, so HOLD covers the rest.
    localparam logic [CW-1:0] LOAD = CW'(COIN_MIN - 1);

    coin_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          raw_q;

    // State, counter and previous raw level; reset forces IDLE immediately.
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= COIN_IDLE;
            cnt_q   <= '0;
            raw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raw_q   <= coin_raw;
        end
    end

    // Next state: start on a raw rising edge, leave HOLD as the countdown reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            COIN_IDLE: begin
                if (coin_raw && !raw_q) begin
                    state_d = COIN_HOLD;
                    cnt_d   = LOAD;
                end
            end
            COIN_HOLD: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = COIN_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = COIN_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign coin = (state_q == COIN_HOLD) | coin_raw;

endmodule

// File: rtl/bw_input_ctrl.sv
// rtl/bw_input_ctrl.sv - keyboard/joystick/DIP input mapping for the Black Widow family
module bw_input_ctrl
    import bw_input_pkg::*;
#(
    parameter int COIN_MIN = COIN_MIN_DEFAULT
) (
    input  logic        clk_25,
    input  logic        RESET_L,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [7:0]  input_0,
    output logic [7:0]  input_3,
    output logic [7:0]  input_4,
    output logic [7:0]  sw_d4,
    output logic [7:0]  sw_b4,
    output logic [1:0]  game
);

    logic tog_q, armed_q, key_event, pressed;
    logic k_up, k_down, k_left, k_right, k_start1, k_start2;
    logic k_fire_a, k_fire_b, k_fire_c, k_fire_d, k_coin1, k_coin2;
    logic [7:0] game_reg;
    logic [7:0] sw [8];
    logic up, down, left, right, start1, start2;
    logic fire_right, fire_left, fire_up, fire_down, coin_raw, coin;
    logic title_valid;
    logic [7:0] in0_d, in3_d, in4_d, d4_d, b4_d;
    logic unused_bits;

    assign pressed   = ps2_key[9];
    assign key_event = armed_q && (ps2_key[10] != tog_q);

    // Toggle history; the first edge out of reset only arms, so a stale toggle is not taken as a key.
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
        end
    end

    // Key latches follow the pressed flag of each recognised scan code.
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            k_up     <= 1'b0;
            k_down   <= 1'b0;
            k_left   <= 1'b0;
            k_right  <= 1'b0;
            k_start1 <= 1'b0;
            k_start2 <= 1'b0;
            k_fire_a <= 1'b0;
            k_fire_b <= 1'b0;
            k_fire_c <= 1'b0;
            k_fire_d <= 1'b0;
            k_coin1  <= 1'b0;
            k_coin2  <= 1'b0;
        end else if (key_event) begin
            case (ps2_key[7:0])
                SC_UP:                    k_up     <= pressed;
                SC_DOWN:                  k_down   <= pressed;
                SC_LEFT:                  k_left   <= pressed;
                SC_RIGHT:                 k_right  <= pressed;
                SC_START1_A, SC_START1_B: k_start1 <= pressed;
                SC_START2_A, SC_START2_B: k_start2 <= pressed;
                SC_FIRE_A:                k_fire_a <= pressed;
                SC_FIRE_B:                k_fire_b <= pressed;
                SC_FIRE_C:                k_fire_c <= pressed;
                SC_FIRE_D:                k_fire_d <= pressed;
                SC_COIN1:                 k_coin1  <= pressed;
                SC_COIN2:                 k_coin2  <= pressed;
                default: ;
            endcase
        end
    end

    // Download port: title select and the eight DIP bytes at the bottom of the DIP index.
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            game_reg <= 8'd0;
            for (int i = 0; i < 8; i++) sw[i] <= 8'h00;
        end else begin
            if (ioctl_wr && ioctl_index == IOCTL_IDX_GAME)
                game_reg <= ioctl_dout;
            if (ioctl_wr && ioctl_index == IOCTL_IDX_DIP && ioctl_addr[24:3] == 22'd0)
                sw[ioctl_addr[2:0]] <= ioctl_dout;
        end
    end

    assign up         = k_up     | joy[3];
    assign down       = k_down   | joy[2];
    assign left       = k_left   | joy[1];
    assign right      = k_right  | joy[0];
    assign fire_right = k_fire_a | joy[4];
    assign fire_left  = k_fire_b | joy[5];
    assign fire_up    = k_fire_d | joy[6];
    assign fire_down  = k_fire_c | joy[7];
    assign start1     = k_start1 | joy[8];
    assign start2     = k_start2 | joy[9];
    assign coin_raw   = k_coin1 | k_coin2 | joy[10];

    bw_coin_stretch #(.COIN_MIN(COIN_MIN)) u_coin_stretch (
        .clk_25   (clk_25),
        .RESET_L  (RESET_L),
        .coin_raw (coin_raw),
        .coin     (coin)
    );

    assign title_valid = (game_reg[7:2] == 6'd0);

    // Per-title port layout; idle ports read all ones (active-low cabinet inputs).
    always_comb begin
        in0_d = 8'hFF;
        in3_d = 8'hFF;
        in4_d = 8'hFF;
        d4_d  = sw[0];
        b4_d  = sw[1];
        if (title_valid) begin
            case (game_t'(game_reg[1:0]))
                GAME_BWIDOW: begin
                    in0_d = ~{1'b0, 1'b1, sw[2][0], sw[2][1], 2'b00, coin, 1'b0};
                    in3_d = ~{4'b0000, up, down, left, right};
                    in4_d = ~{1'b0, start2, start1, 1'b0, fire_up, fire_down, fire_left, fire_right};
                end
                GAME_GRAVITAR: begin
                    in0_d = ~{1'b0, 1'b1, sw[2][0], sw[2][1], 2'b00, coin, 1'b0};
                    in3_d = ~{3'b000, fire_left, left, right, fire_right, fire_down};
                    in4_d = ~{1'b0, start2, start1, 5'b00000};
                end
                GAME_LUNARBAT: begin
                    in0_d = ~{1'b0, 1'b1, sw[2][0], sw[2][1], 2'b00, coin, 1'b0};
                    in3_d = {1'b0, start2, start1, fire_left, fire_down, fire_right, right, left};
                    d4_d  = 8'hFF;
                    b4_d  = 8'hFF;
                end
                default: ;
            endcase
        end
    end

    // Output register so every source change shows up exactly one edge later.
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            input_0 <= 8'hBF;
            input_3 <= 8'hFF;
            input_4 <= 8'hFF;
            sw_d4   <= 8'h00;
            sw_b4   <= 8'h00;
            game    <= 2'd0;
        end else begin
            input_0 <= in0_d;
            input_3 <= in3_d;
            input_4 <= in4_d;
            sw_d4   <= d4_d;
            sw_b4   <= b4_d;
            game    <= game_reg[1:0];
        end
    end

    assign unused_bits = ^{ps2_key[8], sw[2][7:2], sw[3], sw[4], sw[5], sw[6], sw[7]};

endmodule
